// File: rtl/prop_monitor.sv
// Run-time protocol monitor: evaluates six temporal/combinational checks on the
// monitored signals and reports per-check pulses, sticky flags, a count and the first failure.
module prop_monitor #(
  parameter int N_CH     = 2,
  parameter int DATA_W   = 8,
  parameter int DATA_MAX = 200,
  parameter int LAG      = 2,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   en,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  input  logic [DATA_W-1:0] data,
  input  logic              chk_disable,
  input  logic              clear,
  input  logic [5:0]        chk_en,
  output logic [5:0]        err_pulse,
  output logic [5:0]        err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [2:0]        first_id,
  output logic              first_vld
);

  localparam logic [DATA_W-1:0] DATA_LIMIT = DATA_MAX[DATA_W-1:0];
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  typedef enum logic [2:0] {
    CHK_EN_COVER = 3'd0,
    CHK_SAME     = 3'd1,
    CHK_NEXT     = 3'd2,
    CHK_DELAY    = 3'd3,
    CHK_BOUND    = 3'd4,
    CHK_SEQ      = 3'd5
  } chk_id_t;

  // Pending obligations carried between edges.
  logic           next_pend;
  logic [LAG-1:0] delay_sr;
  logic           seq_s1;
  logic           seq_s2;
  logic           seq_s3;

  logic           next_pend_nxt;
  logic [LAG-1:0] delay_sr_nxt;
  logic [LAG:0]   delay_ext;
  logic           seq_s1_nxt;
  logic           seq_s2_nxt;
  logic           seq_s3_nxt;

  logic [5:0]       fail;
  logic [5:0]       pulse_nxt;
  logic [5:0]       sticky_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [2:0]       first_id_nxt;
  logic             first_vld_nxt;

  function automatic logic [2:0] lowest_set(input logic [5:0] bits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (bits[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Failure detection on the values sampled at this edge.
  always_comb begin
    fail               = '0;
    fail[CHK_EN_COVER] = ~|en;
    fail[CHK_SAME]     = a & ~b & ~c;
    fail[CHK_NEXT]     = next_pend & ~c;
    fail[CHK_DELAY]    = delay_sr[LAG-1] & ~d & ~chk_disable;
    fail[CHK_BOUND]    = data > DATA_LIMIT;
    fail[CHK_SEQ]      = seq_s3 & ~d & ~chk_disable;
  end

  // Pending-state update; the mask never touches this, so obligations survive masking.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    next_pend_nxt = a & ~b;
    delay_ext     = {delay_sr, b & c & d};
    delay_sr_nxt  = delay_ext[LAG-1:0];
    seq_s1_nxt    = a;
    seq_s2_nxt    = seq_s1 & c;
    seq_s3_nxt    = seq_s2 & b;
    if (chk_disable) begin
      delay_sr_nxt = '0;
      seq_s1_nxt   = 1'b0;
      seq_s2_nxt   = 1'b0;
      seq_s3_nxt   = 1'b0;
    end
  end

  // Reporting: clear wipes the history first, then this edge's failures are recorded.
  always_comb begin
    pulse_nxt     = fail & chk_en;
    sticky_nxt    = err_sticky;
    count_nxt     = err_count;
    first_id_nxt  = first_id;
    first_vld_nxt = first_vld;
    if (clear) begin
      sticky_nxt    = '0;
      count_nxt     = '0;
      first_id_nxt  = 3'd0;
      first_vld_nxt = 1'b0;
    end
    if (|pulse_nxt) begin
      sticky_nxt = sticky_nxt | pulse_nxt;
      if (count_nxt != CNT_SAT) count_nxt = count_nxt + CNT_W'(1);
      if (!first_vld_nxt) begin
        first_id_nxt  = lowest_set(pulse_nxt);
        first_vld_nxt = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_pend  <= 1'b0;
      delay_sr   <= '0;
      seq_s1     <= 1'b0;
      seq_s2     <= 1'b0;
      seq_s3     <= 1'b0;
      err_pulse  <= '0;
      err_sticky <= '0;
      err_count  <= '0;
      first_id   <= 3'd0;
      first_vld  <= 1'b0;
    end else begin
      next_pend  <= next_pend_nxt;
      delay_sr   <= delay_sr_nxt;
      seq_s1     <= seq_s1_nxt;
      seq_s2     <= seq_s2_nxt;
      seq_s3     <= seq_s3_nxt;
      err_pulse  <= pulse_nxt;
      err_sticky <= sticky_nxt;
      err_count  <= count_nxt;
      first_id   <= first_id_nxt;
      first_vld  <= first_vld_nxt;
    end
  end

endmodule

// File: tb/tb_prop_monitor.sv
// Scoreboard bench for prop_monitor: a default instance plus a 12-bit data /
// 2-bit counter instance, both fed the same control stimulus.
module tb_prop_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  en;
  logic        a, b, c, d;
  logic [7:0]  data;
  logic [11:0] alt_data;
  logic        chk_disable;
  logic        clear;
  logic [5:0]  chk_en;

  logic [5:0] err_pulse, err_sticky;
  logic [7:0] err_count;
  logic [2:0] first_id;
  logic       first_vld;

  logic [5:0] alt_pulse, alt_sticky;
  logic [1:0] alt_count;
  logic [2:0] alt_first_id;
  logic       alt_first_vld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prop_monitor u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .data(data), .chk_disable(chk_disable), .clear(clear), .chk_en(chk_en),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .first_id(first_id), .first_vld(first_vld)
  );

  prop_monitor #(.DATA_W(12), .DATA_MAX(3000), .CNT_W(2)) u_alt (
    .clk(clk), .reset_n(reset_n), .en(en), .a(a), .b(b), .c(c), .d(d),
    .data(alt_data), .chk_disable(chk_disable), .clear(clear), .chk_en(chk_en),
    .err_pulse(alt_pulse), .err_sticky(alt_sticky), .err_count(alt_count),
    .first_id(alt_first_id), .first_vld(alt_first_vld)
  );

  typedef struct {
    int         idx;
    logic [5:0] p, st;
    logic [7:0] cnt;
    logic [2:0] fid;
    logic       fv;
    logic [5:0] ap, ast;
    logic [1:0] acnt;
    logic [2:0] afid;
    logic       afv;
  } exp_t;

  exp_t q[$];

  // Expected reporting state, accumulated from the hand-computed pulses.
  logic [5:0] m_st,  a_st;
  logic [7:0] m_cnt;
  logic [1:0] a_cnt;
  logic [2:0] m_fid, a_fid;
  logic       m_fv,  a_fv;
  int         vec_no = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [5:0] p);
    for (int i = 0; i < 6; i++) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_st = '0; m_cnt = '0; m_fid = '0; m_fv = 1'b0;
    a_st = '0; a_cnt = '0; a_fid = '0; a_fv = 1'b0;
  endtask

  // One stimulus edge: drive at negedge, queue the expected response of the next posedge.
  task automatic vec(input logic [5:0] ep, input logic [3:0] abcd = 4'b0000,
                     input logic [1:0] ien = 2'b01, input logic dis = 1'b0,
                     input logic clr = 1'b0, input logic [7:0] dat = 8'd0,
                     input logic [11:0] adat = 12'd0, input logic [5:0] ce = 6'h3f,
                     input logic ea4 = 1'b0);
    exp_t e;
    logic [5:0] ap;
    @(negedge clk);
    en = ien; {a, b, c, d} = abcd; data = dat; alt_data = adat;
    chk_disable = dis; clear = clr; chk_en = ce;
    ap = {ep[5], ea4, ep[3:0]};
    if (clr) begin
      m_st = '0; m_cnt = '0; m_fid = '0; m_fv = 1'b0;
      a_st = '0; a_cnt = '0; a_fid = '0; a_fv = 1'b0;
    end
    if (|ep) begin
      m_st |= ep;
      if (m_cnt != 8'hff) m_cnt++;
      if (!m_fv) begin m_fv = 1'b1; m_fid = lowest(ep); end
    end
    if (|ap) begin
      a_st |= ap;
      if (a_cnt != 2'b11) a_cnt++;
      if (!a_fv) begin a_fv = 1'b1; a_fid = lowest(ap); end
    end
    vec_no++;
    e.idx = vec_no;
    e.p = ep;  e.st = m_st; e.cnt = m_cnt; e.fid = m_fid; e.fv = m_fv;
    e.ap = ap; e.ast = a_st; e.acnt = a_cnt; e.afid = a_fid; e.afv = a_fv;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    en = 2'b01; {a, b, c, d} = 4'b0000; data = '0; alt_data = '0;
    chk_disable = 1'b0; clear = 1'b0; chk_en = 6'h3f;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drain", q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"},  err_pulse,  6'd0);
    check({tag, "_sticky"}, err_sticky, 6'd0);
    check({tag, "_count"},  err_count,  8'd0);
    check({tag, "_first"},  {first_vld, first_id}, 4'd0);
    check({tag, "_alt"},    {alt_pulse, alt_sticky, alt_count}, 14'd0);
  endtask

  // Monitor: every posedge the DUTs present a response to the oldest queued vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("v%0d_pulse", e.idx),      err_pulse,     e.p);
        check($sformatf("v%0d_sticky", e.idx),     err_sticky,    e.st);
        check($sformatf("v%0d_count", e.idx),      err_count,     e.cnt);
        check($sformatf("v%0d_first_id", e.idx),   first_id,      e.fid);
        check($sformatf("v%0d_first_vld", e.idx),  first_vld,     e.fv);
        check($sformatf("v%0d_alt_pulse", e.idx),  alt_pulse,     e.ap);
        check($sformatf("v%0d_alt_sticky", e.idx), alt_sticky,    e.ast);
        check($sformatf("v%0d_alt_count", e.idx),  alt_count,     e.acnt);
        check($sformatf("v%0d_alt_first", e.idx),  {alt_first_vld, alt_first_id}, {e.afv, e.afid});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Enable coverage: en drops to zero for one edge.
    vec(6'b000000, 4'b0000, 2'b11);
    vec(6'b000001, 4'b0000, 2'b00);
    vec(6'b000000);

    // Same-cycle and next-cycle implications with a held a=1,b=0,c=0.
    vec(6'b000010, 4'b1000);
    vec(6'b000110, 4'b1000);
    vec(6'b000000, 4'b0010);
    vec(6'b000000);
    vec(6'b000000);

    // Delayed implication, LAG=2.
    vec(6'b000000, 4'b0111);
    vec(6'b000000, 4'b0000);
    vec(6'b001000, 4'b0000);
    vec(6'b000000);
    // Disable at the intermediate edge flushes the trigger.
    vec(6'b000000, 4'b0111);
    vec(6'b000000, 4'b0000, 2'b01, 1'b1);
    vec(6'b000000, 4'b0000);
    vec(6'b000000);
    // Overlapping triggers each checked.
    vec(6'b000000, 4'b0111);
    vec(6'b000000, 4'b0111);
    vec(6'b001000, 4'b0000);
    vec(6'b001000, 4'b0000);
    vec(6'b000000);
    // Trigger coincident with disable is not captured.
    vec(6'b000000, 4'b0111, 2'b01, 1'b1);
    vec(6'b000000, 4'b0000);
    vec(6'b000000, 4'b0000);

    // Data bound: 180, 200 pass; 210 fails; alt instance 3000 passes, 3001 fails.
    vec(6'b000000, 4'b0000, 2'b01, 1'b0, 1'b0, 8'd180, 12'd3000);
    vec(6'b000000, 4'b0000, 2'b01, 1'b0, 1'b0, 8'd200, 12'd0);
    vec(6'b010000, 4'b0000, 2'b01, 1'b0, 1'b0, 8'd210, 12'd3001, 6'h3f, 1'b1);
    vec(6'b010000, 4'b0000, 2'b01, 1'b0, 1'b0, 8'd255, 12'd4095, 6'h3f, 1'b1);
    vec(6'b000000);

    // Three-step sequence a, c, b then !d.
    vec(6'b000000, 4'b1100);
    vec(6'b000000, 4'b0010);
    vec(6'b000000, 4'b0100);
    vec(6'b100000, 4'b0000);
    vec(6'b000000);
    // Same sequence closed with d=1.
    vec(6'b000000, 4'b1100);
    vec(6'b000000, 4'b0010);
    vec(6'b000000, 4'b0100);
    vec(6'b000000, 4'b0001);
    vec(6'b000000);
    // Two attempts offset by one edge.
    vec(6'b000000, 4'b1100);
    vec(6'b000000, 4'b1110);
    vec(6'b000000, 4'b0110);
    vec(6'b100000, 4'b0100);
    vec(6'b100000, 4'b0000);
    vec(6'b000000);
    // Disable on the final edge suppresses the failure.
    vec(6'b000000, 4'b1100);
    vec(6'b000000, 4'b0010);
    vec(6'b000000, 4'b0100);
    vec(6'b000000, 4'b0000, 2'b01, 1'b1);
    vec(6'b000000);

    // Mask: checks 1/2 masked on the trigger edge, check 2 still owed next edge.
    vec(6'b000000, 4'b1000, 2'b01, 1'b0, 1'b0, 8'd0, 12'd0, 6'b111001);
    vec(6'b000100, 4'b0000);
    vec(6'b000000, 4'b0000, 2'b00, 1'b0, 1'b0, 8'd0, 12'd0, 6'b111110);
    vec(6'b000000);

    // Clear does not flush a pending check-3 trigger.
    vec(6'b000000, 4'b0111);
    vec(6'b000000, 4'b0000, 2'b01, 1'b0, 1'b1);
    vec(6'b001000, 4'b0000);
    vec(6'b000000);

    // Clear coincident with a check-4 failure, then saturate the 2-bit counter.
    vec(6'b010000, 4'b0000, 2'b01, 1'b0, 1'b1, 8'd210, 12'd3001, 6'h3f, 1'b1);
    for (int i = 0; i < 5; i++) vec(6'b000001, 4'b0000, 2'b00);
    vec(6'b000000, 4'b0000, 2'b01, 1'b0, 1'b1);
    vec(6'b000000);

    // Reset mid-sequence: pending check-3 and check-5 obligations are dropped.
    vec(6'b000000, 4'b1100);
    vec(6'b000000, 4'b0111);
    drain();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    vec(6'b000000, 4'b0100);
    vec(6'b000000, 4'b0000);
    vec(6'b000000, 4'b0000);
    vec(6'b000000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prop_monitor.md
Name: prop_monitor

Overview:
- Synthesizable run-time protocol monitor. Implements in RTL the property set the team checks in simulation: enable coverage, same-cycle and next-cycle implications, delayed implication, data bound, and a 3-step sequence.
- Generalised over enable-channel count, data width, data bound and delay depth.
- Reports per-check error pulses, sticky flags, a saturating error counter and the first-failure ID.
- Sits beside the datapath under test, in silicon or FPGA; no effect on the monitored signals.

Parameters:
- N_CH, 2, number of enable channels.
- DATA_W, 8, data bus width.
- DATA_MAX, 200, inclusive upper bound for data (unsigned).
- LAG, 2, cycles between trigger and consequent for check 3 (LAG >= 1).
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  N_CH  enable channels.
- a, b, c, d  in  1 each  monitored control signals.
- data  in  DATA_W  monitored data.
- chk_disable  in  1  synchronous "disable iff" for temporal checks 3 and 5.
- clear  in  1  synchronous clear of sticky, count and first-failure state.
- chk_en  in  6  per-check report mask.
- err_pulse  out  6  one-cycle per-check failure flags.
- err_sticky  out  6  accumulated failures.
- err_count  out  CNT_W  saturating count of failing edges.
- first_id  out  3  index of first failure.
- first_vld  out  1  first_id is valid.

Behaviour:
- Reset: reset_n is asynchronous and active-low. While low, all outputs and internal pipelines are 0; released state is idle with nothing pending.
- Sampling: inputs are sampled at each rising edge k. A failure detected at edge k appears on err_pulse during cycle k..k+1 (1-cycle registered latency).
- Checks (bit index):
  - 0: |en == 0.
  - 1: a && !b && !c, same edge.
  - 2: a && !b at edge k, and !c at edge k+1.
  - 3: b && c && d at edge k, and !d at edge k+LAG. Uses an LAG-deep trigger shift register; overlapping triggers are each checked.
  - 4: data > DATA_MAX, unsigned compare.
  - 5: a at k, c at k+1, b at k+2, and !d at k+3. Implemented as a 3-stage pipeline (s1=a; s2=s1&&c; s3=s2&&b; fail = s3&&!d) so overlapping attempts are tracked independently.
- Disable: chk_disable high at edge k clears all pending check-3 triggers and check-5 stages, and suppresses check 3/5 failures at k. A trigger present at k is not captured. Checks 0, 1, 2, 4 are unaffected.
- Mask: chk_en[i]=0 forces err_pulse[i]=0. Masked checks still evaluate and track pending state internally, so re-enabling does not lose obligations. Masked failures do not affect sticky, count or first_id.
- err_sticky[i] sets on err_pulse[i]; cleared only by reset or clear.
- err_count increments by 1 per edge with any err_pulse bit set, regardless of how many bits are set. Saturates at 2^CNT_W-1; no wrap.
- first_id/first_vld latch the lowest set bit index on the first failing edge after reset/clear. Held until the next clear.
- clear with a simultaneous failure: clear applies first, then the new failure is recorded (sticky = new bits, count = 1, first_id = new).
- clear does not flush pending pipelines; only reset_n and chk_disable do.
- Reset asserted mid-sequence: all pending obligations are lost; no failure is reported for them after release.

Test Plan:
- en=2'b11 then 2'b00 for one edge -> err_pulse[0] for one cycle; err_count=1, first_id=0, first_vld=1.
- a=1,b=0,c=0 held two edges -> err_pulse[1] at first edge; err_pulse[1]|[2] at second edge; err_count=2.
- b=c=d=1 one edge, then d=0 for two edges (LAG=2) -> err_pulse[3] exactly two edges after trigger. Repeat with chk_disable=1 at the intermediate edge -> no err_pulse[3].
- data=180 then 200 then 210 -> err_pulse[4] only for 210. With DATA_W=12, DATA_MAX=3000, data=3001 -> err_pulse[4].
- a, then c, then b on consecutive edges, then d=0 -> err_pulse[5]. Same sequence with d=1 -> no error. Two overlapping sequences offset by one edge -> two separate err_pulse[5].
- CNT_W=2 with 5 failing edges -> err_count saturates at 3. Then clear on the same edge as a check-4 failure -> err_count=1, err_sticky=6'b010000, first_id=4.
